// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared types and constants for the serial bit feeder
//
// Purpose : holds the feeder state encoding and the default payload width.
// Contents: ser_state_t   - IDLE / SHIFT / PARITY state enum
//           SER_DEFAULT_WIDTH - default number of payload bits per word
package ser_pkg;

  localparam int SER_DEFAULT_WIDTH = 8;

  // PARITY is only ever entered when SER_PARITY_EN is defined.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

endpackage

// File: rtl/ser_parity.sv
// rtl/ser_parity.sv - even-parity generator for one payload word
//
// Purpose : combinational XOR reduction of a payload word. Only compiled
//           when SER_PARITY_EN is defined, so the default build carries no
//           parity logic at all.
// Ports   : data   [WIDTH-1:0] in  - payload word
//           parity             out - XOR of all payload bits
`ifdef SER_PARITY_EN
module ser_parity #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  assign parity = ^data;

endmodule
`endif

// File: rtl/serial_bit_feeder.sv
// rtl/serial_bit_feeder.sv - parallel word to registered serial bit stream
//
// Purpose : accepts WIDTH-bit words on a valid/ready handshake and emits them
//           one bit per clock on x/x_valid, MSB or LSB first. Back-to-back
//           words produce a gapless stream.
// Macro   : SER_PARITY_EN - when defined, each word is followed by one even
//           parity bit in state PARITY.
// Ports   : clk                     in  - single clock, rising edge
//           rst                     in  - synchronous active-high reset
//           in_data  [WIDTH-1:0]    in  - parallel word
//           in_valid                in  - in_data is valid
//           in_ready                out - word accepted this cycle if valid
//           x                       out - registered serial bit (0 when idle)
//           x_valid                 out - registered, x carries a real bit
//           busy                    out - state is not IDLE
module serial_bit_feeder
  import ser_pkg::*;
#(
  parameter int WIDTH     = SER_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic             last_bit;

  // Bit that leaves the word first in the configured order.
  function automatic logic first_bit(input logic [WIDTH-1:0] d);
    return MSB_FIRST ? d[WIDTH-1] : d[0];
  endfunction

  // Word with its first bit consumed, so first_bit() yields the next one.
  function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] d);
    return MSB_FIRST ? {d[WIDTH-2:0], 1'b0} : {1'b0, d[WIDTH-1:1]};
  endfunction

`ifdef SER_PARITY_EN
  logic parity_q, parity_d;
  logic word_parity;

  ser_parity #(.WIDTH(WIDTH)) u_parity (
    .data   (in_data),
    .parity (word_parity)
  );
`endif

  assign last_bit = (cnt_q == LAST_CNT);
  assign x        = x_q;
  assign x_valid  = xv_q;
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      x_q      <= 1'b0;
      xv_q     <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      x_q      <= x_d;
      xv_q     <= xv_d;
`ifdef SER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // x/x_valid are registered: the next-cycle bit is chosen here, so loading a
  // word presents its first bit directly and the shift register keeps only
  // the remaining bits.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    x_d      = 1'b0;
    xv_d     = 1'b0;
    in_ready = 1'b0;
`ifdef SER_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        cnt_d    = '0;
        if (in_valid) begin
          state_d = SHIFT;
          x_d     = first_bit(in_data);
          xv_d    = 1'b1;
          shreg_d = drop_bit(in_data);
`ifdef SER_PARITY_EN
          parity_d = word_parity;
`endif
        end
      end

      SHIFT: begin
        if (!last_bit) begin
          x_d     = first_bit(shreg_q);
          xv_d    = 1'b1;
          shreg_d = drop_bit(shreg_q);
          cnt_d   = cnt_q + CW'(1);
        end else begin
`ifdef SER_PARITY_EN
          state_d = PARITY;
          x_d     = parity_q;
          xv_d    = 1'b1;
          cnt_d   = '0;
`else
          // Last bit on the wire: a new word may be taken now so its first
          // bit follows with no gap.
          in_ready = 1'b1;
          cnt_d    = '0;
          if (in_valid) begin
            x_d     = first_bit(in_data);
            xv_d    = 1'b1;
            shreg_d = drop_bit(in_data);
          end else begin
            state_d = IDLE;
          end
`endif
        end
      end

`ifdef SER_PARITY_EN
      PARITY: begin
        in_ready = 1'b1;
        cnt_d    = '0;
        if (in_valid) begin
          state_d  = SHIFT;
          x_d      = first_bit(in_data);
          xv_d     = 1'b1;
          shreg_d  = drop_bit(in_data);
          parity_d = word_parity;
        end else begin
          state_d = IDLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (rst) begin
      in_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb/tb_serial_bit_feeder.sv - directed self-checking bench for serial_bit_feeder
module tb_serial_bit_feeder;

`ifdef SER_PARITY_EN
  localparam int WLEN = 9;
`else
  localparam int WLEN = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       rdy_m, x_m, xv_m, busy_m;
  logic       rdy_l, x_l, xv_l, busy_l;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_m), .x(x_m), .x_valid(xv_m), .busy(busy_m)
  );

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_l), .x(x_l), .x_valid(xv_l), .busy(busy_l)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at cycle +1 of an accepted word w; walks its WLEN output cycles.
  // in_data is scrambled while it must not matter; on the final cycle the
  // next word (nv/nd) is offered, which is where in_ready must be high.
  task automatic emit_word(input string tag, input logic [7:0] w,
                           input logic nv, input logic [7:0] nd);
    logic eb_m, eb_l;
    for (int j = 0; j < WLEN; j++) begin
      if (j < 8) begin
        eb_m = w[7-j];
        eb_l = w[j];
      end else begin
        eb_m = ^w;
        eb_l = ^w;
      end
      if (j == WLEN - 1) begin
        in_valid = nv;
        in_data  = nd;
      end else begin
        in_data = 8'($urandom);
      end
      #1;
      chk($sformatf("%s x_m[%0d]", tag, j), 32'(x_m), 32'(eb_m));
      chk($sformatf("%s x_l[%0d]", tag, j), 32'(x_l), 32'(eb_l));
      chk($sformatf("%s xv[%0d]", tag, j), 32'({xv_m, xv_l}), 32'b11);
      chk($sformatf("%s busy[%0d]", tag, j), 32'({busy_m, busy_l}), 32'b11);
      chk($sformatf("%s rdy[%0d]", tag, j), 32'({rdy_m, rdy_l}),
          (j == WLEN - 1) ? 32'b11 : 32'b00);
      step();
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " xv"}, 32'({xv_m, xv_l}), 32'b00);
    chk({tag, " x"}, 32'({x_m, x_l}), 32'b00);
    chk({tag, " busy"}, 32'({busy_m, busy_l}), 32'b00);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    step();
    step();
    // Reset state, in_ready forced low while rst is high.
    chk_idle("reset");
    chk("reset rdy", 32'({rdy_m, rdy_l}), 32'b00);
    rst = 1'b0;
    #1;
    chk("post-reset rdy", 32'({rdy_m, rdy_l}), 32'b11);

    // Scenario 1: A5 from IDLE, then idle on cycle +9.
    in_data  = 8'hA5;
    in_valid = 1'b1;
    #1;
    chk("s1 rdy0", 32'(rdy_m), 32'd1);
    step();
    in_valid = 1'b0;
    emit_word("s1", 8'hA5, 1'b0, 8'h00);
    chk_idle("s1 end");

    // Scenario 2: 0A then A0 with in_valid held high -> gapless stream.
    in_data  = 8'h0A;
    in_valid = 1'b1;
    #1;
    chk("s2 rdy0", 32'(rdy_m), 32'd1);
    step();
    emit_word("s2a", 8'h0A, 1'b1, 8'hA0);
    in_valid = 1'b0;
    emit_word("s2b", 8'hA0, 1'b0, 8'h00);
    chk_idle("s2 end");

    // Scenario 3: 01 -> LSB-first instance shows 1 then zeros.
    in_data  = 8'h01;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    emit_word("s3", 8'h01, 1'b0, 8'h00);
    chk_idle("s3 end");

    // Scenario 4: 07 (parity 1) then 03 (parity 0), back to back.
    in_data  = 8'h07;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    emit_word("s4a", 8'h07, 1'b1, 8'h03);
    in_valid = 1'b0;
    emit_word("s4b", 8'h03, 1'b0, 8'h00);
    chk_idle("s4 end");

    // Scenario 5: reset on the 4th bit of FF aborts the word.
    in_data  = 8'hFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("s5 x[%0d]", j), 32'({x_m, x_l, xv_m}), 32'b111);
      if (j < 3) step();
    end
    rst = 1'b1;
    step();
    chk_idle("s5 abort");
    chk("s5 rdy in rst", 32'(rdy_m), 32'd0);
    rst = 1'b0;
    #1;
    chk("s5 rdy after rst", 32'({rdy_m, rdy_l}), 32'b11);
    in_data  = 8'h81;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    emit_word("s5n", 8'h81, 1'b0, 8'h00);
    chk_idle("s5 end");

    // Scenario 6: C3 with in_data scrambled every cycle in flight.
    in_data  = 8'hC3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    emit_word("s6", 8'hC3, 1'b0, 8'h00);
    chk_idle("s6 end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
